// File: rtl/jlc3_pkg.sv
// Shared definitions for the jlc3 SoC peripheral glue.
// Holds the UART TX arbiter state encoding, the UART byte width and a
// helper that sizes index fields so that a single-entry set still gets one bit.
package jlc3_pkg;

    // Byte width carried by the SoC UART.
    localparam int JLC3_UART_DW = 8;

    // UART TX arbiter sequencer states (fixed 2-bit encoding).
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } arb_state_e;

    // Width of an index able to address n items, never narrower than 1 bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : jlc3_pkg

// File: rtl/jlc3_rr_pick.sv
// Combinational round-robin picker.
// Scans the valid vector starting one position above ptr and wrapping
// around, returning the first valid entry as a one-hot grant plus its index.
// Shared by the UART TX arbiter and the bus arbiter.
module jlc3_rr_pick
    import jlc3_pkg::*;
#(
    parameter int N = 2,
    localparam int IW = idx_width(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    // Two passes: first the entries above ptr, then the wrapped entries up to ptr.
    always_comb begin
        // NOTE: every output gets a default before the scan so no latch is inferred.
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!any && valid[i] && (i > int'(ptr))) begin
                any      = 1'b1;
                grant[i] = 1'b1;
                idx      = IW'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!any && valid[i] && (i <= int'(ptr))) begin
                any      = 1'b1;
                grant[i] = 1'b1;
                idx      = IW'(i);
            end
        end
    end

endmodule : jlc3_rr_pick

// File: rtl/jlc3_uart_tx_arb.sv
// UART TX arbiter and sequencer.
// Shares the single UART transmitter between NREQ byte requesters: grants one
// requester at a time in round-robin order, latches its byte, pulses a start
// strobe to the TX core and then follows tx_busy until the frame has gone out.
// txd itself stays inside the TX core.
module jlc3_uart_tx_arb
    import jlc3_pkg::*;
#(
    parameter int NREQ         = 2,
    parameter int DATA_W       = JLC3_UART_DW,
    parameter int BUSY_TIMEOUT = 16,
    localparam int IW          = idx_width(NREQ)
) (
    input  logic                     clk_i_w,
    input  logic                     rst_i_w,
    input  logic                     en_i_w,
    input  logic [NREQ-1:0]          req_valid_i_w,
    input  logic [NREQ*DATA_W-1:0]   req_data_i_w,
    output logic [NREQ-1:0]          req_ready_o_r,
    output logic                     tx_start_o_r,
    output logic [DATA_W-1:0]        tx_data_o_r,
    input  logic                     tx_busy_i_w,
    output logic [IW-1:0]            grant_id_o_r,
    output logic                     active_o_r,
    output logic                     timeout_o_r
);

    // Counter holds 0..BUSY_TIMEOUT-1 while waiting for the TX core to go busy.
    localparam int CW = idx_width(BUSY_TIMEOUT);
    localparam logic [CW-1:0] WAIT_LAST = CW'(BUSY_TIMEOUT - 1);
    localparam logic [IW-1:0] PTR_INIT  = IW'(NREQ - 1);

    arb_state_e         state;
    logic [IW-1:0]      rr_ptr;
    logic [CW-1:0]      wait_cnt;

    logic [NREQ-1:0]    pick_grant;
    logic [IW-1:0]      pick_idx;
    logic               pick_any;
    logic [DATA_W-1:0]  win_data;
    logic               grant_ok;

    jlc3_rr_pick #(
        .N (NREQ)
    ) u_pick (
        .valid (req_valid_i_w),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // Select the winning requester's byte with the one-hot grant.
    always_comb begin
        win_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_grant[i]) begin
                win_data = req_data_i_w[i*DATA_W +: DATA_W];
            end
        end
    end

    // A new grant needs the block enabled, a pending byte and an idle transmitter.
    assign grant_ok = en_i_w && pick_any && !tx_busy_i_w;

    // Sequencer: grant, start strobe, wait for busy to rise, wait for busy to fall.
    always_ff @(posedge clk_i_w or negedge rst_i_w) begin
        if (!rst_i_w) begin
            // NOTE: sequential state uses non-blocking assignments so every flop
            // samples the pre-edge values of the others.
            state         <= ST_IDLE;
            rr_ptr        <= PTR_INIT;
            wait_cnt      <= '0;
            req_ready_o_r <= '0;
            tx_start_o_r  <= 1'b0;
            tx_data_o_r   <= '0;
            grant_id_o_r  <= '0;
            active_o_r    <= 1'b0;
            timeout_o_r   <= 1'b0;
        end else begin
            // Ready and start are single-cycle pulses unless re-asserted below.
            req_ready_o_r <= '0;
            tx_start_o_r  <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (grant_ok) begin
                        req_ready_o_r <= pick_grant;
                        tx_data_o_r   <= win_data;
                        grant_id_o_r  <= pick_idx;
                        rr_ptr        <= pick_idx;
                        active_o_r    <= 1'b1;
                        state         <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    tx_start_o_r <= 1'b1;
                    wait_cnt     <= '0;
                    state        <= ST_WAIT_BUSY;
                end

                ST_WAIT_BUSY: begin
                    if (tx_busy_i_w) begin
                        state <= ST_WAIT_DONE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        // The TX core never acknowledged the start; give up on this byte.
                        timeout_o_r <= 1'b1;
                        active_o_r  <= 1'b0;
                        state       <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                ST_WAIT_DONE: begin
                    if (!tx_busy_i_w) begin
                        active_o_r <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end

                default: begin
                    active_o_r <= 1'b0;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : jlc3_uart_tx_arb

// File: tb/tb_jlc3_uart_tx_arb.sv
// Self-checking bench for jlc3_uart_tx_arb (NREQ=2, DATA_W=8, BUSY_TIMEOUT=16).
// Stimulus pushes the expected grant id and byte into scoreboard queues; a
// monitor pops them whenever the DUT pulses ready or start.
module tb_jlc3_uart_tx_arb;

    localparam int NREQ = 2;
    localparam int DW   = 8;

    typedef struct {
        int        id;
        logic [7:0] data;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic              en;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              tx_start;
    logic [DW-1:0]     tx_data;
    logic              tx_busy;
    logic [0:0]        grant_id;
    logic              active;
    logic              timeout;

    int   pending [NREQ];
    logic model_on;
    logic model_busy;
    logic forced_busy;
    int   busy_len;

    exp_t rdy_q[$];
    exp_t tx_q[$];

    int n_checks = 0;
    int n_err    = 0;
    int ready_cnt = 0;
    int start_cnt = 0;

    jlc3_uart_tx_arb #(
        .NREQ         (NREQ),
        .DATA_W       (DW),
        .BUSY_TIMEOUT (16)
    ) dut (
        .clk_i_w       (clk),
        .rst_i_w       (rst_n),
        .en_i_w        (en),
        .req_valid_i_w (req_valid),
        .req_data_i_w  (req_data),
        .req_ready_o_r (req_ready),
        .tx_start_o_r  (tx_start),
        .tx_data_o_r   (tx_data),
        .tx_busy_i_w   (tx_busy),
        .grant_id_o_r  (grant_id),
        .active_o_r    (active),
        .timeout_o_r   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign tx_busy = model_busy | forced_busy;

    always_comb begin
        req_valid = '0;
        for (int i = 0; i < NREQ; i++) req_valid[i] = (pending[i] != 0);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    task automatic push_exp(input int id, input logic [7:0] d);
        exp_t e;
        e.id   = id;
        e.data = d;
        rdy_q.push_back(e);
        tx_q.push_back(e);
    endtask

    function automatic int onehot_idx(input logic [NREQ-1:0] v);
        int r = -1;
        for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
        return r;
    endfunction

    function automatic bit pending_any();
        bit r = 0;
        for (int i = 0; i < NREQ; i++) if (pending[i] != 0) r = 1;
        return r;
    endfunction

    // Stimulus and stimulus-side checks happen 2 time units after the rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            tick();
            n++;
        end while ((pending_any() || active || tx_busy) && n < 300);
        if (n >= 300) fail_now("wait_idle_timeout");
    endtask

    // Requesters: a byte is consumed when valid and ready meet at a rising edge.
    initial begin
        logic [NREQ-1:0] hs;
        forever begin
            @(negedge clk);
            hs = req_ready & req_valid;
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++) if (hs[i] && pending[i] > 0) pending[i]--;
        end
    end

    // TX core model: busy rises the cycle after start and stays high busy_len cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (tx_start && model_on) begin
                @(posedge clk);
                #1 model_busy = 1'b1;
                repeat (busy_len) @(posedge clk);
                #1 model_busy = 1'b0;
            end
        end
    end

    // Monitor: compare every ready and start pulse against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (req_ready != '0) begin
                    ready_cnt++;
                    check("ready_onehot", 32'($onehot(req_ready)), 32'd1);
                    check("ready_to_valid_only", 32'(req_ready & ~req_valid), 32'd0);
                    if (rdy_q.size() == 0) begin
                        fail_now("ready_unexpected");
                    end else begin
                        e = rdy_q.pop_front();
                        check("ready_id", 32'(onehot_idx(req_ready)), 32'(e.id));
                    end
                end
                if (tx_start) begin
                    start_cnt++;
                    if (tx_q.size() == 0) begin
                        fail_now("start_unexpected");
                    end else begin
                        e = tx_q.pop_front();
                        check("start_grant_id", 32'(grant_id), 32'(e.id));
                        check("start_tx_data", 32'(tx_data), 32'(e.data));
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int base_r;
        int base_s;
        int n;

        rst_n       = 1'b0;
        en          = 1'b1;
        req_data    = '0;
        model_on    = 1'b1;
        model_busy  = 1'b0;
        forced_busy = 1'b0;
        busy_len    = 10;
        for (int i = 0; i < NREQ; i++) pending[i] = 0;

        // Reset values.
        repeat (3) tick();
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_start", 32'(tx_start), 32'd0);
        check("rst_data", 32'(tx_data), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd0);
        check("rst_active", 32'(active), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single byte 0x41 from requester 0, busy held 10 cycles.
        req_data[0*DW +: DW] = 8'h41;
        push_exp(0, 8'h41);
        pending[0] = 1;
        n = 0;
        do begin tick(); n++; end while (!tx_busy && n < 50);
        if (n >= 50) fail_now("t1_busy_never_rose");
        n = 0;
        do begin tick(); n++; end while (tx_busy && n < 50);
        check("t1_active_while_busy_falls", 32'(active), 32'd1);
        check("t1_data_stable", 32'(tx_data), 32'h41);
        tick();
        check("t1_active_after_done", 32'(active), 32'd0);
        wait_idle();

        // Reset restores rr_ptr so requester 0 wins first; both valid -> 0,1,0,1.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        busy_len = 3;
        req_data[0*DW +: DW] = 8'h30;
        req_data[1*DW +: DW] = 8'h31;
        push_exp(0, 8'h30);
        push_exp(1, 8'h31);
        push_exp(0, 8'h30);
        push_exp(1, 8'h31);
        pending[0] = 2;
        pending[1] = 2;
        wait_idle();
        check("t2_last_grant", 32'(grant_id), 32'd1);

        // Busy never rises: timeout after 16 WAIT_BUSY cycles, then service resumes.
        model_on = 1'b0;
        req_data[0*DW +: DW] = 8'h55;
        push_exp(0, 8'h55);
        pending[0] = 1;
        n = 0;
        do begin tick(); n++; end while (!tx_start && n < 20);
        if (n >= 20) fail_now("t3_no_start");
        n = 0;
        do begin tick(); n++; end while (!timeout && n < 40);
        check("t3_timeout_cycles", 32'(n), 32'd16);
        check("t3_timeout_flag", 32'(timeout), 32'd1);
        check("t3_idle_after_timeout", 32'(active), 32'd0);
        model_on = 1'b1;
        req_data[1*DW +: DW] = 8'h66;
        push_exp(1, 8'h66);
        pending[1] = 1;
        wait_idle();
        check("t3_timeout_sticky", 32'(timeout), 32'd1);

        // Enable low blocks grants; dropping it mid-frame lets the frame finish only.
        en = 1'b0;
        req_data[0*DW +: DW] = 8'h70;
        req_data[1*DW +: DW] = 8'h71;
        base_r = ready_cnt;
        base_s = start_cnt;
        pending[0] = 1;
        pending[1] = 1;
        repeat (8) tick();
        check("t4_no_ready_when_disabled", 32'(ready_cnt - base_r), 32'd0);
        check("t4_no_start_when_disabled", 32'(start_cnt - base_s), 32'd0);
        push_exp(0, 8'h70);
        en = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!tx_busy && n < 50);
        en = 1'b0;
        n = 0;
        do begin tick(); n++; end while (active && n < 50);
        repeat (6) tick();
        check("t4_one_byte_sent", 32'(start_cnt - base_s), 32'd1);
        check("t4_req1_still_pending", 32'(pending[1]), 32'd1);
        check("t4_stays_idle", 32'(active), 32'd0);
        push_exp(1, 8'h71);
        en = 1'b1;
        wait_idle();

        // Busy high while idle holds off the grant until it falls.
        forced_busy = 1'b1;
        req_data[0*DW +: DW] = 8'h5A;
        base_r = ready_cnt;
        pending[0] = 1;
        repeat (6) tick();
        check("t5_no_ready_while_busy", 32'(ready_cnt - base_r), 32'd0);
        push_exp(0, 8'h5A);
        forced_busy = 1'b0;
        check("t5_ready_not_yet", 32'(req_ready), 32'd0);
        tick();
        check("t5_ready_next_cycle", 32'(req_ready), 32'b01);
        wait_idle();

        // Reset during WAIT_DONE clears everything; arbitration restarts at 0.
        req_data[1*DW +: DW] = 8'h99;
        push_exp(1, 8'h99);
        pending[1] = 1;
        busy_len = 8;
        n = 0;
        do begin tick(); n++; end while (!tx_busy && n < 50);
        tick();
        check("t6_active_before_rst", 32'(active), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_ready", 32'(req_ready), 32'd0);
        check("t6_rst_start", 32'(tx_start), 32'd0);
        check("t6_rst_data", 32'(tx_data), 32'd0);
        check("t6_rst_grant_id", 32'(grant_id), 32'd0);
        check("t6_rst_active", 32'(active), 32'd0);
        check("t6_rst_timeout", 32'(timeout), 32'd0);
        n = 0;
        do begin tick(); n++; end while (tx_busy && n < 50);
        rst_n = 1'b1;
        tick();
        busy_len = 3;
        req_data[0*DW +: DW] = 8'h12;
        req_data[1*DW +: DW] = 8'h34;
        push_exp(0, 8'h12);
        push_exp(1, 8'h34);
        pending[0] = 1;
        pending[1] = 1;
        wait_idle();

        repeat (4) tick();
        check("ready_queue_drained", 32'(rdy_q.size()), 32'd0);
        check("start_queue_drained", 32'(tx_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule : tb_jlc3_uart_tx_arb

// File: doc/jlc3_uart_tx_arb.md
Name: jlc3_uart_tx_arb

Overview:
Round-robin arbiter and sequencer that shares the SoC's single UART transmitter between NREQ byte requesters, such as the CPU MMIO port and a debug/boot-message source. It accepts one byte at a time over a valid/ready handshake and issues a one-cycle start pulse to the transmitter. It then tracks the transmitter's busy signal until the frame completes. It sits between the requesters and the UART TX core inside jlc3_soc; txd itself remains owned by the TX core.

Parameters:
NREQ, 2, number of requesters (2..8)
DATA_W, 8, byte width forwarded to the transmitter
BUSY_TIMEOUT, 16, maximum cycles to wait for tx_busy_i_w to rise after start before aborting (>=2)

Ports:
clk_i_w  in  1  system clock
rst_i_w  in  1  asynchronous active-low reset
en_i_w  in  1  global enable; low blocks new grants
req_valid_i_w  in  NREQ  per-requester byte valid
req_data_i_w  in  NREQ*DATA_W  per-requester byte; requester i uses slice [i*DATA_W +: DATA_W]
req_ready_o_r  out  NREQ  one-hot acceptance pulse
tx_start_o_r  out  1  one-cycle start strobe to the UART TX core
tx_data_o_r  out  DATA_W  byte presented to the TX core, stable from start until done
tx_busy_i_w  in  1  TX core busy (high while the frame shifts out)
grant_id_o_r  out  max(1,clog2(NREQ))  index of the last granted requester
active_o_r  out  1  high whenever the state is not IDLE
timeout_o_r  out  1  sticky flag: a start was never acknowledged by busy

Behaviour:
- Reset (rst_i_w=0, asynchronous): state=IDLE; all outputs 0; tx_data_o_r=0; grant_id_o_r=0; rr_ptr=NREQ-1 so requester 0 wins first; timeout counter=0.
- FSM: IDLE -> ISSUE -> WAIT_BUSY -> WAIT_DONE -> IDLE.
- IDLE:
  - Grant only if en_i_w=1, some valid bit is set, and tx_busy_i_w=0.
  - Winner = first valid index scanning (rr_ptr+1) mod NREQ upward with wrap.
  - Same cycle: req_ready_o_r[winner]=1 (registered output, so visible in the accept cycle). Capture the winner's data into tx_data_o_r, set grant_id_o_r=winner and rr_ptr=winner. Next state ISSUE.
  - A requester's byte is consumed when valid&ready are both high in one clock.
- ISSUE: tx_start_o_r=1 for exactly this one cycle; clear the timeout counter; next state WAIT_BUSY.
- WAIT_BUSY:
  - tx_busy_i_w=1 -> WAIT_DONE.
  - Otherwise increment the counter. If the counter reaches BUSY_TIMEOUT-1 with busy still low, set timeout_o_r=1 and go to IDLE.
- WAIT_DONE: tx_busy_i_w=0 -> IDLE. No timeout applies in this state.
- Latency: accept at cycle N, start at N+1, earliest busy at N+2. The next grant comes no earlier than the cycle after busy falls, giving a minimum of 4 cycles per byte.
- en_i_w falling mid-transaction: the in-flight byte completes normally; only new grants are blocked.
- Valid dropped by a requester before it is granted: nothing is captured. Ready is never asserted to a non-valid requester.
- All requesters valid: strict rotation 0,1,..,NREQ-1,0. A sole requester is granted back-to-back.
- tx_busy_i_w high in IDLE (another master or leftover frame): no grant until it falls.
- timeout_o_r clears only on reset.
- Reset asserted mid-operation: immediate return to reset values. tx_start_o_r drops asynchronously, and an accepted but unsent byte is lost.

Decomposition:
- Shared package jlc3_pkg holds the FSM state encoding (2-bit: IDLE=0, ISSUE=1, WAIT_BUSY=2, WAIT_DONE=3) and the JLC3_UART_DW=8 constant.
- One sub-module, jlc3_rr_pick: combinational round-robin picker with inputs valid vector and rr_ptr, and outputs a one-hot winner plus index. It is reused by the future bus arbiter.

Test Plan:
- Reset, then req_valid=01 with data0=8'h41 -> ready[0] pulses 1 cycle; tx_start 1 cycle later with tx_data=8'h41. Model busy high 10 cycles -> active_o_r falls the cycle after busy falls.
- Both valid continuously (data0=8'h30, data1=8'h31), 4 bytes -> grants in order 0,1,0,1 and tx_data sequence 30,31,30,31; each ready is one-hot.
- Start issued but busy never rises -> after 16 WAIT_BUSY cycles timeout_o_r=1 and state is IDLE. The next request is still served and timeout_o_r stays 1.
- en_i_w=0 with valid=11 -> no ready or start. en dropped during WAIT_DONE -> the current byte completes and no new grant follows. en=1 -> the grant resumes at rr_ptr+1.
- tx_busy_i_w=1 while idle with valid=01 -> no ready until busy=0, then ready[0] the next cycle.
- rst_i_w pulsed low during WAIT_DONE -> all outputs 0 immediately, grant_id_o_r=0, and the next arbitration picks requester 0.
